// File: rtl/hilo_unit.sv
// HI/LO register unit: issues multiplies to an external sequential unsigned
// multiplier, applies signed fix-up, and serves MTHI/MTLO/MFHI/MFLO. Optional MADDU via HILO_MADD_EN.
module hilo_unit (
    input  logic        i_sys_clock,
    input  logic        i_sys_reset,
    input  logic        i_hilo_op_valid,
    input  logic [2:0]  i_hilo_op,
    input  logic [31:0] i_hilo_rs,
    input  logic [31:0] i_hilo_rt,
    output logic        o_hilo_stall,
    output logic [31:0] o_hilo_rdata,
    output logic        o_hilo_rdata_valid,
    output logic        o_mult_start,
    output logic [31:0] o_mult_a,
    output logic [31:0] o_mult_b,
    input  logic        i_mult_done,
    input  logic [31:0] i_mult_hi,
    input  logic [31:0] i_mult_lo
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MADDU = OP_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_FIX   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [PROD_W-1:0]   fix_res;
    logic                neg_q, neg_d;
    logic                start_q;
    logic                op_active;
    logic                accept;
    logic                rd_valid;
`ifdef HILO_MADD_EN
    logic                madd_q, madd_d;
`endif

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    // Reset gates the decode so stall and read-valid are low during reset.
    always_comb begin
        op_active = i_hilo_op_valid && (i_hilo_op != OP_NOP) && !i_sys_reset;
`ifndef HILO_MADD_EN
        if (i_hilo_op == OP_MADDU) begin
            op_active = 1'b0;
        end
`endif
        accept   = op_active && (state_q == ST_IDLE);
        rd_valid = accept && ((i_hilo_op == OP_MFHI) || (i_hilo_op == OP_MFLO));
    end

    assign o_hilo_stall       = op_active && (state_q != ST_IDLE);
    assign o_hilo_rdata_valid = rd_valid;
    assign o_hilo_rdata       = !rd_valid ? DATA_W'(0) :
                                (i_hilo_op == OP_MFHI) ? hi_q : lo_q;
    assign o_mult_start       = start_q;
    assign o_mult_a           = a_q;
    assign o_mult_b           = b_q;

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        fix_res = neg_q ? (~prod_q + PROD_W'(1)) : prod_q;
`ifdef HILO_MADD_EN
        madd_d  = madd_q;
        if (madd_q) begin
            fix_res = {hi_q, lo_q} + prod_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (i_hilo_op)
                        OP_MULTU: begin
                            a_d     = i_hilo_rs;
                            b_d     = i_hilo_rt;
                            neg_d   = 1'b0;
`ifdef HILO_MADD_EN
                            madd_d  = 1'b0;
`endif
                            state_d = ST_START;
                        end
                        OP_MULT: begin
                            a_d     = mag(i_hilo_rs);
                            b_d     = mag(i_hilo_rt);
                            neg_d   = i_hilo_rs[DATA_W-1] ^ i_hilo_rt[DATA_W-1];
`ifdef HILO_MADD_EN
                            madd_d  = 1'b0;
`endif
                            state_d = ST_START;
                        end
`ifdef HILO_MADD_EN
                        OP_MADDU: begin
                            a_d     = i_hilo_rs;
                            b_d     = i_hilo_rt;
                            neg_d   = 1'b0;
                            madd_d  = 1'b1;
                            state_d = ST_START;
                        end
`endif
                        OP_MTHI: hi_d = i_hilo_rs;
                        OP_MTLO: lo_d = i_hilo_rs;
                        default: ;
                    endcase
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (i_mult_done) begin
                    prod_d  = {i_mult_hi, i_mult_lo};
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = fix_res[PROD_W-1:DATA_W];
                lo_d    = fix_res[DATA_W-1:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            start_q <= 1'b0;
`ifdef HILO_MADD_EN
            madd_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            start_q <= (state_d == ST_START);
`ifdef HILO_MADD_EN
            madd_q  <= madd_d;
`endif
        end
    end

endmodule
